// File: rtl/stream_downsize_pkg.sv
// Shared types for the stream width-conversion blocks.
package stream_downsize_pkg;

  // Downsizer holding-register occupancy: empty, low/first half pending,
  // second half pending.
  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } ds_state_t;

endpackage

// File: rtl/stream_downsize.sv
// Splits each 2*DATA_WD input beat into two DATA_WD output beats.
// A one-entry holding register lets the next input beat load on the same
// cycle the current second half leaves, so the output can run at one beat
// per cycle.
module stream_downsize
  import stream_downsize_pkg::*;
#(
  parameter int DATA_WD   = 4,
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [2*DATA_WD-1:0] s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [DATA_WD-1:0]   m_data,
  output logic                 m_last,
  input  logic                 m_ready
);

  ds_state_t              state;
  ds_state_t              state_nxt;
  logic [2*DATA_WD-1:0]   buf_data;
  logic                   buf_last;
  logic                   s_fire;
  logic                   m_fire;
  logic [DATA_WD-1:0]     first_half;
  logic [DATA_WD-1:0]     second_half;

  // The register frees up in the same cycle its second half is taken, so
  // m_ready feeds s_ready combinationally. s_ready never looks at s_valid.
  assign s_ready = !rst && ((state == ST_EMPTY) ||
                            ((state == ST_SECOND) && m_ready));
  assign m_valid = (state != ST_EMPTY);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  // Pick which half of the held beat goes out first.
  if (LOW_FIRST) begin : g_low_first
    assign first_half  = buf_data[DATA_WD-1:0];
    assign second_half = buf_data[2*DATA_WD-1:DATA_WD];
  end else begin : g_high_first
    assign first_half  = buf_data[2*DATA_WD-1:DATA_WD];
    assign second_half = buf_data[DATA_WD-1:0];
  end

  assign m_data = (state == ST_SECOND) ? second_half : first_half;
  assign m_last = (state == ST_SECOND) && buf_last;

  // Next-state logic: hold unless the relevant handshake completes.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt; no latch inferred.
    state_nxt = state;
    case (state)
      ST_EMPTY:  if (s_fire) state_nxt = ST_FIRST;
      ST_FIRST:  if (m_fire) state_nxt = ST_SECOND;
      ST_SECOND: if (m_fire) state_nxt = s_valid ? ST_FIRST : ST_EMPTY;
      default:   state_nxt = ST_EMPTY;
    endcase
  end

  // State and holding register; the buffer only loads on an accepted input.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from
    // pre-edge values.
    if (rst) begin
      state    <= ST_EMPTY;
      // NOTE: the holding register is reset too, so m_data reads 0 after
      // reset instead of stale or X data.
      buf_data <= '0;
      buf_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (s_fire) begin
        buf_data <= s_data;
        buf_last <= s_last;
      end
    end
  end

endmodule
